// File: rtl/ram_4r1w_bist.sv
// Built-in self test for the 4-read/1-write RAM: fills every word with an address-derived
// pattern, reads it back over all four read ports and counts/records mismatches.
module ram_4r1w_bist #(
   parameter int          BLOCKSIZE = 10,
   parameter int          DWIDTH    = 32,
   parameter int          RD_LAT    = 1,
   parameter logic [15:0] SEED      = 16'hA5C3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [BLOCKSIZE:0] w_addr_1,
   output logic [DWIDTH-1:0] w_din_1,
   output logic              w_enb_1,
   output logic [BLOCKSIZE:0] r_addr_1,
   output logic [BLOCKSIZE:0] r_addr_2,
   output logic [BLOCKSIZE:0] r_addr_3,
   output logic [BLOCKSIZE:0] r_addr_4,
   input  logic [DWIDTH-1:0] r_dout_1,
   input  logic [DWIDTH-1:0] r_dout_2,
   input  logic [DWIDTH-1:0] r_dout_3,
   input  logic [DWIDTH-1:0] r_dout_4,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [BLOCKSIZE:0] fail_addr,
   output logic [1:0]        fail_port
);

   localparam int AW = BLOCKSIZE + 1;
   localparam logic [AW-1:0] LAST_W = {AW{1'b1}};
   localparam logic [AW-1:0] LAST_R = LAST_W - AW'(3);

   typedef enum logic [2:0] {IDLE, WRITE, DRAIN, READ, FLUSH, DONE} state_t;

   state_t            r_state;
   logic [2:0]        r_flush;
   logic [RD_LAT-1:0] r_vld;
   logic [AW-1:0]     r_base [RD_LAT];

   logic              w_chk_vld;
   logic [AW-1:0]     w_b;
   logic [3:0]        w_mis;
   logic [2:0]        w_nmis;
   logic [1:0]        w_first_port;
   logic [15:0]       w_err_next;

   function automatic logic [31:0] pat(input logic [AW-1:0] a);
      logic [15:0] a16;
      a16 = 16'(a);
      return {SEED ^ a16, a16};
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [2:0] n);
      logic [16:0] s;
      s = {1'b0, c} + {14'd0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   // Check stage: the oldest pipeline entry lines up with the returning read data
   always_comb begin
      w_chk_vld = r_vld[RD_LAT-1];
      w_b       = r_base[RD_LAT-1];
      w_mis[0]  = (r_dout_1 != pat(w_b));
      w_mis[1]  = (r_dout_2 != pat(w_b + AW'(1)));
      w_mis[2]  = (r_dout_3 != pat(w_b + AW'(2)));
      w_mis[3]  = (r_dout_4 != pat(w_b + AW'(3)));
      w_nmis    = {2'd0, w_mis[0]} + {2'd0, w_mis[1]} + {2'd0, w_mis[2]} + {2'd0, w_mis[3]};
      if (w_mis[0])      w_first_port = 2'd0;
      else if (w_mis[1]) w_first_port = 2'd1;
      else if (w_mis[2]) w_first_port = 2'd2;
      else               w_first_port = 2'd3;
      w_err_next = w_chk_vld ? sat_add(err_cnt, w_nmis) : err_cnt;
   end

   // Base addresses ride alongside the valid bits; only the valid bits need clearing
   always_ff @(posedge clk) begin
      r_base[0] <= r_addr_1;
      for (int i = 1; i < RD_LAT; i++) r_base[i] <= r_base[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_flush   <= 3'd0;
         r_vld     <= '0;
         w_addr_1  <= '0;
         w_din_1   <= '0;
         w_enb_1   <= 1'b0;
         r_addr_1  <= '0;
         r_addr_2  <= '0;
         r_addr_3  <= '0;
         r_addr_4  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= 16'd0;
         fail_addr <= '0;
         fail_port <= 2'd0;
      end else begin
         r_vld[0] <= (r_state == READ);
         for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];

         // err_cnt is still zero only until the first mismatching cycle of the run
         err_cnt <= w_err_next;
         if (w_chk_vld && (|w_mis) && (err_cnt == 16'd0)) begin
            fail_addr <= w_b + AW'(w_first_port);
            fail_port <= w_first_port;
         end

         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state   <= WRITE;
                  w_enb_1   <= 1'b1;
                  w_addr_1  <= '0;
                  w_din_1   <= pat('0);
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_cnt   <= 16'd0;
                  fail_addr <= '0;
                  fail_port <= 2'd0;
               end
            end
            WRITE: begin
               if (w_addr_1 == LAST_W) begin
                  r_state  <= DRAIN;
                  w_enb_1  <= 1'b0;
                  w_addr_1 <= '0;
                  w_din_1  <= '0;
               end else begin
                  w_addr_1 <= w_addr_1 + AW'(1);
                  w_din_1  <= pat(w_addr_1 + AW'(1));
               end
            end
            DRAIN: begin
               r_state  <= READ;
               r_addr_1 <= AW'(0);
               r_addr_2 <= AW'(1);
               r_addr_3 <= AW'(2);
               r_addr_4 <= AW'(3);
            end
            READ: begin
               if (r_addr_1 == LAST_R) begin
                  r_state  <= FLUSH;
                  r_flush  <= 3'(RD_LAT - 1);
                  r_addr_1 <= '0;
                  r_addr_2 <= '0;
                  r_addr_3 <= '0;
                  r_addr_4 <= '0;
               end else begin
                  r_addr_1 <= r_addr_1 + AW'(4);
                  r_addr_2 <= r_addr_2 + AW'(4);
                  r_addr_3 <= r_addr_3 + AW'(4);
                  r_addr_4 <= r_addr_4 + AW'(4);
               end
            end
            FLUSH: begin
               // The final compare lands in the last flush cycle, so pass uses the updated count
               if (r_flush == 3'd0) begin
                  r_state <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (w_err_next == 16'd0);
               end else begin
                  r_flush <= r_flush - 3'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_4r1w_bist.sv
// Bench for ram_4r1w_bist: two instances (read latency 1 and 2) each wired to a behavioural
// RAM with a per-address fault mask that corrupts read data.
module tb_ram_4r1w_bist;

   localparam int D  = 2048;
   localparam int AW = 11;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        start_w;
   logic [AW-1:0]     wa [2];
   logic [31:0]       wd [2];
   logic [1:0]        we;
   logic [AW-1:0]     ra [2][4];
   logic [31:0]       rd [2][4];
   logic [1:0]        busy_w, done_w, pass_w;
   logic [15:0]       err_w [2];
   logic [AW-1:0]     fa_w [2];
   logic [1:0]        fp_w [2];

   logic [31:0]       mem1 [D];
   logic [31:0]       mem2 [D];
   logic [31:0]       st2  [4];
   logic [31:0]       fm   [D];

   int n_cmp;
   int n_mis;

   always #5 clk = ~clk;

   ram_4r1w_bist #(.BLOCKSIZE(10), .DWIDTH(32), .RD_LAT(1), .SEED(16'hA5C3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_w[0]),
      .w_addr_1(wa[0]), .w_din_1(wd[0]), .w_enb_1(we[0]),
      .r_addr_1(ra[0][0]), .r_addr_2(ra[0][1]), .r_addr_3(ra[0][2]), .r_addr_4(ra[0][3]),
      .r_dout_1(rd[0][0]), .r_dout_2(rd[0][1]), .r_dout_3(rd[0][2]), .r_dout_4(rd[0][3]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
      .fail_addr(fa_w[0]), .fail_port(fp_w[0])
   );

   ram_4r1w_bist #(.BLOCKSIZE(10), .DWIDTH(32), .RD_LAT(2), .SEED(16'hA5C3)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_w[1]),
      .w_addr_1(wa[1]), .w_din_1(wd[1]), .w_enb_1(we[1]),
      .r_addr_1(ra[1][0]), .r_addr_2(ra[1][1]), .r_addr_3(ra[1][2]), .r_addr_4(ra[1][3]),
      .r_dout_1(rd[1][0]), .r_dout_2(rd[1][1]), .r_dout_3(rd[1][2]), .r_dout_4(rd[1][3]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
      .fail_addr(fa_w[1]), .fail_port(fp_w[1])
   );

   // One-cycle RAM for instance 1, two-cycle RAM for instance 2
   always @(posedge clk) begin
      if (we[0]) mem1[wa[0]] <= wd[0];
      for (int n = 0; n < 4; n++) rd[0][n] <= mem1[ra[0][n]] ^ fm[ra[0][n]];
   end

   always @(posedge clk) begin
      if (we[1]) mem2[wa[1]] <= wd[1];
      for (int n = 0; n < 4; n++) begin
         st2[n]   <= mem2[ra[1][n]] ^ fm[ra[1][n]];
         rd[1][n] <= st2[n];
      end
   end

   typedef struct {
      int            nf;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [15:0]   e_err;
      logic [AW-1:0] e_fa;
      logic [1:0]    e_fp;
      logic          e_pass;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic logic outs_nz(input int w);
      return |{wa[w], wd[w], we[w], ra[w][0], ra[w][1], ra[w][2], ra[w][3],
               busy_w[w], done_w[w], pass_w[w], err_w[w], fa_w[w], fp_w[w]};
   endfunction

   function automatic void clear_faults();
      for (int a = 0; a < D; a++) fm[a] = 32'd0;
   endfunction

   // Reads go out in ascending address order, so the first failing word is the lowest faulty address
   function automatic void model(output logic [15:0] e, output logic [AW-1:0] fa,
                                 output logic [1:0] fp);
      int  cnt;
      bit  found;
      cnt = 0; found = 0; fa = '0; fp = '0;
      for (int a = 0; a < D; a++) begin
         if (fm[a] != 32'd0) begin
            cnt++;
            if (!found) begin
               found = 1;
               fa    = AW'(a);
               fp    = 2'(a % 4);
            end
         end
      end
      e = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
   endfunction

   task automatic run_one(input int w, input bit detail, input bit extra, output int dcyc);
      int cyc;
      bit got;
      @(negedge clk);
      start_w[w] = 1'b1;
      @(negedge clk);
      start_w[w] = 1'b0;
      cyc = 1;
      got = 0;
      chk("clr_err", err_w[w], 16'd0);
      chk("clr_done", done_w[w], 1'b0);
      chk("clr_pass", pass_w[w], 1'b0);
      chk("busy_k1", busy_w[w], 1'b1);
      while (!got && cyc < 4000) begin
         if (detail) begin
            if (cyc == 1) chk("wr_k1", {wa[w], wd[w], we[w]}, {11'd0, 32'hA5C30000, 1'b1});
            if (cyc == 6) chk("wr_k6", {wa[w], wd[w], we[w]}, {11'd5, 32'hA5C60005, 1'b1});
            if (cyc == D + 1) chk("drain_noenb", we[w], 1'b0);
            if (cyc == D + 2)
               chk("rd_k2050", {ra[w][0], ra[w][1], ra[w][2], ra[w][3]},
                   {11'd0, 11'd1, 11'd2, 11'd3});
            if (cyc == D + 3) chk("rd_k2051", ra[w][3], 11'd7);
         end
         if (extra) begin
            if (cyc == 100 || cyc == 2200) start_w[w] = 1'b1;
            if (cyc == 101 || cyc == 2201) start_w[w] = 1'b0;
         end
         got = done_w[w];
         if (!got) begin
            @(negedge clk);
            cyc++;
         end
      end
      start_w[w] = 1'b0;
      dcyc = got ? cyc : -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            dc;
      int            bad;
      int            nf;
      int            wt;
      logic [15:0]   e_err;
      logic [AW-1:0] e_fa;
      logic [1:0]    e_fp;
      logic [AW-1:0] a;

      n_cmp = 0;
      n_mis = 0;
      start_w = 2'b00;
      rst = 1'b1;
      clear_faults();

      tbl[0] = '{0, 11'h000, 11'h000, 16'd0, 11'h000, 2'd0, 1'b1};
      tbl[1] = '{1, 11'h123, 11'h000, 16'd1, 11'h123, 2'd3, 1'b0};
      tbl[2] = '{2, 11'h200, 11'h203, 16'd2, 11'h200, 2'd0, 1'b0};
      tbl[3] = '{2, 11'h7FE, 11'h7FD, 16'd2, 11'h7FD, 2'd1, 1'b0};
      tbl[4] = '{0, 11'h000, 11'h000, 16'd0, 11'h000, 2'd0, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset_outs_dut1", outs_nz(0), 1'b0);
      chk("reset_outs_dut2", outs_nz(1), 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed table: good run (with ignored extra starts), faults, restart after failure
      for (int i = 0; i < 5; i++) begin
         clear_faults();
         if (tbl[i].nf > 0) fm[tbl[i].a0] = 32'h1;
         if (tbl[i].nf > 1) fm[tbl[i].a1] = 32'h1;
         run_one(0, i == 0, i == 0, dc);
         chk($sformatf("done_cyc[%0d]", i), 64'(dc), 64'd2563);
         chk($sformatf("err_cnt[%0d]", i), err_w[0], tbl[i].e_err);
         chk($sformatf("fail_addr[%0d]", i), fa_w[0], tbl[i].e_fa);
         chk($sformatf("fail_port[%0d]", i), fp_w[0], tbl[i].e_fp);
         chk($sformatf("pass[%0d]", i), pass_w[0], tbl[i].e_pass);
         chk($sformatf("busy_done[%0d]", i), busy_w[0], 1'b0);
         if (i == 0) begin
            bad = 0;
            for (int k = 0; k < D; k++)
               if (mem1[k] !== {16'hA5C3 ^ 16'(k), 16'(k)}) bad++;
            chk("mem_pattern", 64'(bad), 64'd0);
            chk("idle_addr", {wa[0], we[0], ra[0][0], ra[0][3]}, 64'd0);
         end
      end

      // Random fault sets against the reference model
      for (int r = 0; r < 3; r++) begin
         clear_faults();
         nf = $urandom_range(0, 5);
         for (int j = 0; j < nf; j++) begin
            a = AW'($urandom_range(0, D - 1));
            fm[a] = 32'h1 << $urandom_range(0, 31);
         end
         model(e_err, e_fa, e_fp);
         repeat ($urandom_range(0, 7)) @(negedge clk);
         run_one(0, 1'b0, 1'b0, dc);
         chk($sformatf("rnd_done_cyc[%0d]", r), 64'(dc), 64'd2563);
         chk($sformatf("rnd_err[%0d]", r), err_w[0], e_err);
         chk($sformatf("rnd_pass[%0d]", r), pass_w[0], e_err == 16'd0);
         if (e_err != 16'd0) begin
            chk($sformatf("rnd_fa[%0d]", r), fa_w[0], e_fa);
            chk($sformatf("rnd_fp[%0d]", r), fp_w[0], e_fp);
         end
      end

      // Asynchronous reset in the middle of the write phase
      clear_faults();
      @(negedge clk);
      start_w[0] = 1'b1;
      @(negedge clk);
      start_w[0] = 1'b0;
      wt = 0;
      while (wa[0] !== 11'd100 && wt < 300) begin
         @(negedge clk);
         wt++;
      end
      chk("wait_addr100", wa[0], 11'd100);
      rst = 1'b1;
      #1;
      chk("rst_async_outs", outs_nz(0), 1'b0);
      @(posedge clk);
      #1;
      chk("rst_no_write", we[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", {busy_w[0], done_w[0], we[0]}, 3'b000);
      run_one(0, 1'b0, 1'b0, dc);
      chk("post_rst_done_cyc", 64'(dc), 64'd2563);
      chk("post_rst_pass", pass_w[0], 1'b1);

      // Two-cycle read latency instance
      clear_faults();
      run_one(1, 1'b1, 1'b0, dc);
      chk("lat2_done_cyc", 64'(dc), 64'd2564);
      chk("lat2_pass", pass_w[1], 1'b1);
      chk("lat2_err", err_w[1], 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
